alu_step_demo: RTL and testbench

ALU_STEP_DEMO -- requirements
Module: alu_step_demo

---
 rtl/alu_step_demo_if.sv | 27 ++
 rtl/alu_step_demo.sv | 207 ++++++++++++++++++++
 tb/tb_alu_step_demo.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/alu_step_demo_if.sv
// Operand/result bus between the step controller and the external ALU.
// The controller drives operands and control; the ALU returns result and flags.
interface alu_step_demo_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [15:0]      alu_ctrl;
    logic [WIDTH-1:0] alu_out;
    logic [4:0]       alu_flags;

    modport master (
        output alu_a,
        output alu_b,
        output alu_ctrl,
        input  alu_out,
        input  alu_flags
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_ctrl,
        output alu_out,
        output alu_flags
    );
endinterface

// File: rtl/alu_step_demo.sv
// Step-by-step ALU front end: operands and opcode are keyed in a nibble at a
// time from switches, the external ALU is given a fixed settle time, and the
// result is latched for display and can be chained back in as operand A.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ENTER_A  | shifting nibbles into a_reg, one per enter press
// ENTER_B  | shifting nibbles into b_reg, one per enter press
// ENTER_OP | waiting for enter to latch the opcode switches
// EXEC     | ALU settling; wait_cnt counts down, result captured at zero
// SHOW     | result and flags on display; enter chains result into A
module alu_step_demo #(
    parameter int WIDTH     = 16,
    parameter int EXEC_WAIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           sw,
    input  logic [3:0]           op_sw,
    input  logic                 btn_enter,
    input  logic                 btn_clear,
    alu_step_demo_if.master      alu,
    output logic [WIDTH-1:0]     disp_value,
    output logic [4:0]           flag_leds,
    output logic [2:0]           state_leds,
    output logic                 busy
);

    localparam int NIB   = WIDTH / 4;
    localparam int NIB_W = $clog2(NIB);

    localparam logic [NIB_W-1:0] NIB_LAST  = NIB_W'(NIB - 1);
    localparam logic [3:0]       WAIT_LOAD = 4'(EXEC_WAIT);

    localparam logic [2:0] ST_ENTER_A  = 3'd0;
    localparam logic [2:0] ST_ENTER_B  = 3'd1;
    localparam logic [2:0] ST_ENTER_OP = 3'd2;
    localparam logic [2:0] ST_EXEC     = 3'd3;
    localparam logic [2:0] ST_SHOW     = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic             btn_q;
    logic             enter_pulse;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [3:0]       op_reg;
    logic [WIDTH-1:0] result_reg;
    logic [4:0]       flags_reg;
    logic [NIB_W-1:0] nib_cnt;
    logic [3:0]       wait_cnt;
    logic             nib_last;
    logic             wait_done;

    assign enter_pulse = btn_enter & ~btn_q;
    assign nib_last    = (nib_cnt == NIB_LAST);
    assign wait_done   = (wait_cnt == 4'd0);

    // Button history for rising-edge detection; resets high so a button held
    // through reset must be released before it counts again.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q <= 1'b1;
        end else begin
            btn_q <= btn_enter;
        end
    end

    // Next-state selection; clear overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ENTER_A: begin
                if (enter_pulse && nib_last) begin
                    state_nxt = ST_ENTER_B;
                end
            end
            ST_ENTER_B: begin
                if (enter_pulse && nib_last) begin
                    state_nxt = ST_ENTER_OP;
                end
            end
            ST_ENTER_OP: begin
                if (enter_pulse) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (wait_done) begin
                    state_nxt = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (enter_pulse) begin
                    state_nxt = ST_ENTER_B;
                end
            end
            default: begin
                state_nxt = ST_ENTER_A;
            end
        endcase
        if (btn_clear) begin
            state_nxt = ST_ENTER_A;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_ENTER_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand A: nibble shift during entry, reload from result when chaining.
    always_ff @(posedge clk) begin
        if (reset || btn_clear) begin
            a_reg <= '0;
        end else if (enter_pulse) begin
            if (state == ST_ENTER_A) begin
                a_reg <= {a_reg[WIDTH-5:0], sw};
            end else if (state == ST_SHOW) begin
                a_reg <= result_reg;
            end
        end
    end

    // Operand B: nibble shift during entry, emptied when chaining.
    always_ff @(posedge clk) begin
        if (reset || btn_clear) begin
            b_reg <= '0;
        end else if (enter_pulse) begin
            if (state == ST_ENTER_B) begin
                b_reg <= {b_reg[WIDTH-5:0], sw};
            end else if (state == ST_SHOW) begin
                b_reg <= '0;
            end
        end
    end

    // Nibble counter; wraps to zero on the last nibble of each operand.
    always_ff @(posedge clk) begin
        if (reset || btn_clear) begin
            nib_cnt <= '0;
        end else if (enter_pulse) begin
            if ((state == ST_ENTER_A) || (state == ST_ENTER_B)) begin
                nib_cnt <= nib_last ? '0 : nib_cnt + 1'b1;
            end else if (state == ST_SHOW) begin
                nib_cnt <= '0;
            end
        end
    end

    // Opcode latch, taken from the switches on the ENTER_OP press.
    always_ff @(posedge clk) begin
        if (reset || btn_clear) begin
            op_reg <= 4'h0;
        end else if (enter_pulse && (state == ST_ENTER_OP)) begin
            op_reg <= op_sw;
        end
    end

    // Settle timer: loaded on opcode entry, counts down to zero in EXEC.
    always_ff @(posedge clk) begin
        if (reset || btn_clear) begin
            wait_cnt <= 4'd0;
        end else if (enter_pulse && (state == ST_ENTER_OP)) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == ST_EXEC) && !wait_done) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Result and flag capture at terminal count; held until the next capture.
    always_ff @(posedge clk) begin
        if (reset || btn_clear) begin
            result_reg <= '0;
            flags_reg  <= 5'b0;
        end else if ((state == ST_EXEC) && wait_done) begin
            result_reg <= alu.alu_out;
            flags_reg  <= alu.alu_flags;
        end
    end

    // Display source follows what the operator is currently working on.
    always_comb begin
        disp_value = result_reg;
        case (state)
            ST_ENTER_A:  disp_value = a_reg;
            ST_ENTER_B:  disp_value = b_reg;
            ST_ENTER_OP: disp_value = {{(WIDTH-4){1'b0}}, op_sw};
            default:     disp_value = result_reg;
        endcase
    end

    // Continuous bus and indicator outputs.
    always_comb begin
        alu.alu_a    = a_reg;
        alu.alu_b    = b_reg;
        alu.alu_ctrl = {8'h00, op_reg, 4'h0};
        flag_leds    = flags_reg;
        state_leds   = state;
        busy         = (state == ST_EXEC);
    end

endmodule

// File: tb/tb_alu_step_demo.sv
// Directed bench for alu_step_demo: entry, execute, chaining, held button,
// clear and reset-in-EXEC, with a simple adder standing in for the ALU.
module tb_alu_step_demo;

    localparam int WIDTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  sw;
    logic [3:0]  op_sw;
    logic        btn_enter;
    logic        btn_clear;
    logic [15:0] disp_value;
    logic [4:0]  flag_leds;
    logic [2:0]  state_leds;
    logic        busy;
    logic [4:0]  alu_flags_drv;

    int vectors = 0;
    int errors  = 0;

    alu_step_demo_if #(.WIDTH(WIDTH)) bus ();

    assign bus.alu_out   = bus.alu_a + bus.alu_b;
    assign bus.alu_flags = alu_flags_drv;

    alu_step_demo #(.WIDTH(WIDTH), .EXEC_WAIT(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .sw         (sw),
        .op_sw      (op_sw),
        .btn_enter  (btn_enter),
        .btn_clear  (btn_clear),
        .alu        (bus.master),
        .disp_value (disp_value),
        .flag_leds  (flag_leds),
        .state_leds (state_leds),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] nib);
        sw        = nib;
        btn_enter = 1'b1;
        tick();
        btn_enter = 1'b0;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".alu_a"},      32'(bus.alu_a),    32'h0);
        check({tag, ".alu_b"},      32'(bus.alu_b),    32'h0);
        check({tag, ".alu_ctrl"},   32'(bus.alu_ctrl), 32'h0);
        check({tag, ".disp"},       32'(disp_value),   32'h0);
        check({tag, ".flags"},      32'(flag_leds),    32'h0);
        check({tag, ".state"},      32'(state_leds),   32'h0);
        check({tag, ".busy"},       32'(busy),         32'h0);
    endtask

    initial begin
        reset         = 1'b1;
        sw            = 4'h0;
        op_sw         = 4'h0;
        btn_enter     = 1'b0;
        btn_clear     = 1'b0;
        alu_flags_drv = 5'b00010;
        tick();
        tick();
        check_all_zero("reset");

        reset = 1'b0;
        tick();

        // held button shifts exactly one nibble
        sw        = 4'h1;
        btn_enter = 1'b1;
        repeat (10) tick();
        check("held.alu_a", 32'(bus.alu_a), 32'h0001);
        check("held.state", 32'(state_leds), 32'd0);
        btn_enter = 1'b0;
        tick();

        press(4'h2);
        press(4'h3);
        check("entA3.alu_a", 32'(bus.alu_a), 32'h0123);
        check("entA3.disp",  32'(disp_value), 32'h0123);
        press(4'h4);
        check("entA4.alu_a", 32'(bus.alu_a), 32'h1234);
        check("entA4.state", 32'(state_leds), 32'd1);

        press(4'hA);
        press(4'hB);
        press(4'hC);
        check("entB3.disp", 32'(disp_value), 32'h0ABC);
        press(4'hD);
        check("entB4.alu_b", 32'(bus.alu_b), 32'hABCD);
        check("entB4.state", 32'(state_leds), 32'd2);

        op_sw = 4'h5;
        tick();
        check("op.disp", 32'(disp_value), 32'h0005);

        // execute: busy for EXEC_WAIT+1 = 2 cycles, enter during EXEC ignored
        btn_enter = 1'b1;
        tick();
        check("exec1.busy",  32'(busy),         32'd1);
        check("exec1.state", 32'(state_leds),   32'd3);
        check("exec1.ctrl",  32'(bus.alu_ctrl), 32'h0050);
        check("exec1.disp",  32'(disp_value),   32'h0000);
        btn_enter = 1'b0;
        tick();
        check("exec2.busy", 32'(busy), 32'd1);
        btn_enter = 1'b1;
        tick();
        check("show.busy",  32'(busy),       32'd0);
        check("show.state", 32'(state_leds), 32'd4);
        check("show.disp",  32'(disp_value), 32'hBE01);
        check("show.flags", 32'(flag_leds),  32'h02);
        check("show.alu_a", 32'(bus.alu_a),  32'h1234);
        tick();
        tick();
        check("show.nodefer", 32'(state_leds), 32'd4);
        btn_enter = 1'b0;
        tick();

        // chaining
        press(4'hF);
        check("chain.alu_a", 32'(bus.alu_a),  32'hBE01);
        check("chain.alu_b", 32'(bus.alu_b),  32'h0000);
        check("chain.state", 32'(state_leds), 32'd1);
        check("chain.flags", 32'(flag_leds),  32'h02);

        // clear beats a simultaneous enter pulse
        press(4'h7);
        check("preclr.alu_b", 32'(bus.alu_b), 32'h0007);
        sw        = 4'h9;
        btn_enter = 1'b1;
        btn_clear = 1'b1;
        tick();
        check_all_zero("clear");
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        tick();

        // nibble count restarted by clear
        press(4'h1);
        press(4'h0);
        press(4'h0);
        check("postclr3.state", 32'(state_leds), 32'd0);
        check("postclr3.alu_a", 32'(bus.alu_a),  32'h0100);
        press(4'h0);
        check("postclr4.state", 32'(state_leds), 32'd1);
        check("postclr4.alu_a", 32'(bus.alu_a),  32'h1000);

        press(4'h0);
        press(4'h0);
        press(4'h0);
        press(4'h2);
        check("rstB.state", 32'(state_leds), 32'd2);

        // reset during EXEC with enter held across it
        op_sw     = 4'h3;
        btn_enter = 1'b1;
        tick();
        check("rstexec.busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        check_all_zero("rst_exec");
        reset = 1'b0;
        sw    = 4'h9;
        repeat (3) tick();
        check("rsthold.alu_a", 32'(bus.alu_a),  32'h0000);
        check("rsthold.state", 32'(state_leds), 32'd0);
        btn_enter = 1'b0;
        tick();
        press(4'h9);
        check("rstrel.alu_a", 32'(bus.alu_a), 32'h0009);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
